lfsr_rx_checker: RTL and testbench

- Receive-side companion to the team's 4-bit XOR-feedback LFSR serial generator.
- Samples the serial bit stream (OUT/Valid pair) LSB-first and reassembles the word.
- Independently regenerates the expected word from the same SEED, compares the two, and reports the result.
- Sits on the test/BIST path, directly after the generator's serial output.

---
 rtl/lfsr_rx_checker.sv | 171 +++++++++++++++++
 tb/tb_lfsr_rx_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rx_checker.sv
// Receive-side checker for the LFSR serial generator: reassembles the LSB-first serial word,
// regenerates the expected word from SEED and compares. `define LFSR_RX_BIT_ERR_CNT_EN adds BIT_ERR_CNT.
module lfsr_rx_checker #(
    parameter int                    DATA_WIDTH    = 4,
    parameter int                    WARMUP_CYCLES = 8,
    parameter logic [DATA_WIDTH-1:0] TAP_MASK      = 4'b0111
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] SEED,
    input  logic                  SER_IN,
    input  logic                  SER_VALID,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic [DATA_WIDTH-1:0] EXP_DATA,
    output logic                  DONE,
    output logic                  MATCH,
    output logic                  FRAME_ERR,
    output logic                  OVERRUN,
    output logic                  SEED_ZERO
`ifdef LFSR_RX_BIT_ERR_CNT_EN
    ,
    output logic [$clog2(DATA_WIDTH+1)-1:0] BIT_ERR_CNT
`endif
);

    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);

    // The receive path runs independently of warm-up; WARMUP and ARMED differ only in
    // whether the expected word is frozen yet.
    typedef enum logic [2:0] {
        ST_WARMUP,
        ST_ARMED,
        ST_RECV,
        ST_REPORT,
        ST_HOLD
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] lfsr;
    logic [DATA_WIDTH-1:0] lfsr_next;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [CNT_W-1:0]      bit_cnt;
    logic [WARM_W-1:0]     warm_cnt;
    logic                  warm_done;
    logic                  warm_last;
    logic                  last_bit;
    logic                  frame_full;
    logic                  capture;
    logic                  report_en;
    logic                  overrun_set;

    assign warm_done  = (warm_cnt == WARM_W'(WARMUP_CYCLES));
    assign warm_last  = (warm_cnt == WARM_W'(WARMUP_CYCLES - 1));
    assign last_bit   = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign frame_full = (bit_cnt == CNT_W'(DATA_WIDTH));

    always_comb begin
        lfsr_next = {^(lfsr & TAP_MASK), lfsr[DATA_WIDTH-1:1]};
        // Received bits sit at the top of sr; right-align so unreceived bits read as 0.
        rx_word   = sr >> (DATA_WIDTH - int'(bit_cnt));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_WARMUP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_next  = state;
        capture     = 1'b0;
        report_en   = 1'b0;
        overrun_set = 1'b0;
        case (state)
            ST_WARMUP, ST_ARMED, ST_RECV: begin
                if (SER_VALID) begin
                    capture    = 1'b1;
                    state_next = last_bit ? ST_REPORT : ST_RECV;
                end else if (state == ST_RECV) begin
                    state_next = ST_REPORT;
                end else if (state == ST_WARMUP && warm_last) begin
                    state_next = ST_ARMED;
                end
            end
            ST_REPORT: begin
                overrun_set = SER_VALID;
                if (warm_done) begin
                    report_en  = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                overrun_set = SER_VALID;
            end
            default: begin
                state_next = ST_HOLD;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // SEED is a live input, so reset loads it rather than a constant.
            lfsr      <= SEED;
            SEED_ZERO <= (SEED == '0);
            warm_cnt  <= '0;
            EXP_DATA  <= '0;
            sr        <= '0;
            bit_cnt   <= '0;
            RX_DATA   <= '0;
            DONE      <= 1'b0;
            MATCH     <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (!warm_done) begin
                lfsr     <= lfsr_next;
                warm_cnt <= warm_cnt + WARM_W'(1);
                if (warm_last) begin
                    EXP_DATA <= lfsr_next;
                end
            end
            if (capture) begin
                sr      <= {SER_IN, sr[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (report_en) begin
                RX_DATA <= rx_word;
                DONE    <= 1'b1;
                MATCH   <= frame_full && (rx_word == EXP_DATA);
                if (!frame_full) begin
                    FRAME_ERR <= 1'b1;
                end
            end
            if (overrun_set) begin
                OVERRUN <= 1'b1;
            end
        end
    end

`ifdef LFSR_RX_BIT_ERR_CNT_EN
    logic [CNT_W-1:0] bit_err;

    // Only positions actually received are compared, so a short frame is not over-counted.
    always_comb begin
        bit_err = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < int'(bit_cnt) && (rx_word[i] != EXP_DATA[i])) begin
                bit_err = bit_err + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BIT_ERR_CNT <= '0;
        end else if (report_en) begin
            BIT_ERR_CNT <= bit_err;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_rx_checker.sv
// Self-checking bench for lfsr_rx_checker: directed vector table, reset sequences and
// randomized frames checked against a behavioural model.
module tb_lfsr_rx_checker;

    localparam int         W    = 4;
    localparam int         WARM = 8;
    localparam logic [3:0] TAP  = 4'b0111;
    localparam int         MAXE = 20;
    localparam int         NV   = 11;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] seed;
    logic       ser_in;
    logic       ser_valid;
    logic [3:0] rx_data;
    logic [3:0] exp_data;
    logic       done;
    logic       match;
    logic       frame_err;
    logic       overrun;
    logic       seed_zero;
`ifdef LFSR_RX_BIT_ERR_CNT_EN
    logic [2:0] bit_err_cnt;
`endif

    lfsr_rx_checker dut (
        .CLK       (clk),
        .RST       (rst),
        .SEED      (seed),
        .SER_IN    (ser_in),
        .SER_VALID (ser_valid),
        .RX_DATA   (rx_data),
        .EXP_DATA  (exp_data),
        .DONE      (done),
        .MATCH     (match),
        .FRAME_ERR (frame_err),
        .OVERRUN   (overrun),
        .SEED_ZERO (seed_zero)
`ifdef LFSR_RX_BIT_ERR_CNT_EN
        ,
        .BIT_ERR_CNT (bit_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] exp_data;
        logic [3:0] rx_data;
        logic       match;
        logic       ferr;
        logic       ovr;
        logic       sz;
        int         done_edge;
        int         bec;
    } result_t;

    typedef struct packed {
        logic [3:0] seed;
        int         start;
        int         nbits;
        logic [3:0] bits;
        int         extra;
        result_t    want;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    logic stim_val [1:MAXE];
    logic stim_bit [1:MAXE];
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference LFSR step written as arithmetic: parity of tapped bits enters at the top.
    function automatic logic [3:0] lfsr_step(input logic [3:0] v);
        int fb;
        fb = $countones(v & TAP) % 2;
        return 4'((int'(v) >> 1) + fb * 8);
    endfunction

    function automatic logic [3:0] warm_word(input logic [3:0] s);
        logic [3:0] v;
        v = s;
        for (int k = 0; k < WARM; k++) v = lfsr_step(v);
        return v;
    endfunction

    // Expected outcome from the stimulus arrays: collect the first valid run (up to W bits),
    // find the edge that ends the frame, and DONE follows once warm-up is also complete.
    function automatic result_t model(input logic [3:0] s);
        result_t r;
        int      first;
        int      t;
        int      n;
        int      e;
        r          = '0;
        r.exp_data = warm_word(s);
        r.sz       = (s == 4'd0);
        first      = MAXE + 1;
        for (int u = MAXE; u >= 1; u--) if (stim_val[u]) first = u;
        t = first;
        n = 0;
        while (t <= MAXE && n < W) begin
            if (!stim_val[t]) break;
            r.rx_data[n] = stim_bit[t];
            n++;
            t++;
        end
        e           = (n == W) ? t - 1 : t;
        r.done_edge = (e + 1 > WARM + 1) ? e + 1 : WARM + 1;
        for (int u = e + 1; u <= MAXE; u++) if (stim_val[u]) r.ovr = 1'b1;
        r.ferr  = (n != W);
        r.match = (n == W) && (r.rx_data == r.exp_data);
        for (int k = 0; k < n; k++) if (r.rx_data[k] != r.exp_data[k]) r.bec++;
        return r;
    endfunction

    task automatic load_stim(input int start, input int nbits, input logic [3:0] bits, input int extra);
        for (int t = 1; t <= MAXE; t++) begin
            stim_val[t] = 1'b0;
            stim_bit[t] = 1'b0;
        end
        for (int k = 0; k < nbits; k++) begin
            stim_val[start+k] = 1'b1;
            stim_bit[start+k] = bits[k];
        end
        if (extra > 0) begin
            stim_val[extra] = 1'b1;
            stim_bit[extra] = 1'b1;
        end
    endtask

    // Reset, check reset state, release and drive edges 1..MAXE, then check the frame result.
    task automatic run_case(input string tag, input logic [3:0] s, input result_t want);
        int done_cnt;
        int done_at;
        done_cnt  = 0;
        done_at   = -1;
        seed      = s;
        ser_valid = 1'b0;
        ser_in    = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " reset outputs"}, 32'({rx_data, exp_data, done, match, frame_err, overrun}), 32'(0));
        check({tag, " reset seed_zero"}, 32'(seed_zero), 32'(want.sz));
`ifdef LFSR_RX_BIT_ERR_CNT_EN
        check({tag, " reset bit_err_cnt"}, 32'(bit_err_cnt), 32'(0));
`endif
        rst = 1'b0;
        for (int t = 1; t <= MAXE; t++) begin
            ser_valid = stim_val[t];
            ser_in    = stim_bit[t];
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = t;
            end
        end
        ser_valid = 1'b0;
        check({tag, " done pulses"}, 32'(done_cnt), 32'(1));
        check({tag, " done edge"}, 32'(done_at), 32'(want.done_edge));
        check({tag, " exp_data"}, 32'(exp_data), 32'(want.exp_data));
        check({tag, " rx_data"}, 32'(rx_data), 32'(want.rx_data));
        check({tag, " match"}, 32'(match), 32'(want.match));
        check({tag, " frame_err"}, 32'(frame_err), 32'(want.ferr));
        check({tag, " overrun"}, 32'(overrun), 32'(want.ovr));
        check({tag, " seed_zero"}, 32'(seed_zero), 32'(want.sz));
`ifdef LFSR_RX_BIT_ERR_CNT_EN
        check({tag, " bit_err_cnt"}, 32'(bit_err_cnt), 32'(want.bec));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] r_seed;
        logic [3:0] r_bits;
        int         r_start;
        int         r_n;
        int         r_lo;
        int         r_extra;

        rst       = 1'b1;
        seed      = 4'd0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;

        //             seed     start n  bits     extra   exp      rx       m     fe    ov    sz    done bec
        vecs[0]  = '{4'b0001, 9, 4, 4'b1000, 0,  '{4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 13, 0}};
        vecs[1]  = '{4'b1010, 9, 4, 4'b1101, 0,  '{4'b1101, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 13, 0}};
        vecs[2]  = '{4'b1010, 9, 4, 4'b1111, 0,  '{4'b1101, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 13, 1}};
        vecs[3]  = '{4'b0001, 9, 2, 4'b0000, 0,  '{4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 12, 0}};
        vecs[4]  = '{4'b1010, 9, 3, 4'b0110, 0,  '{4'b1101, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 13, 2}};
        vecs[5]  = '{4'b0001, 9, 4, 4'b1000, 13, '{4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0, 13, 0}};
        vecs[6]  = '{4'b0001, 3, 4, 4'b1000, 0,  '{4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 9,  0}};
        vecs[7]  = '{4'b0000, 9, 4, 4'b0000, 0,  '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 13, 0}};
        vecs[8]  = '{4'b1010, 1, 4, 4'b1101, 0,  '{4'b1101, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 9,  0}};
        vecs[9]  = '{4'b0001, 6, 4, 4'b1000, 0,  '{4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 10, 0}};
        vecs[10] = '{4'b0001, 9, 1, 4'b0001, 14, '{4'b1000, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 11, 1}};

        for (int i = 0; i < NV; i++) begin
            load_stim(vecs[i].start, vecs[i].nbits, vecs[i].bits, vecs[i].extra);
            run_case($sformatf("vec%0d", i), vecs[i].seed, vecs[i].want);
        end

        // Flags and data set in HOLD must clear asynchronously, between clock edges.
        #2 rst = 1'b1;
        #1;
        check("hold async reset outputs", 32'({rx_data, exp_data, done, match, frame_err, overrun}), 32'(0));

        // Reset in the middle of a frame, after the expected word is frozen.
        seed      = 4'b0001;
        ser_valid = 1'b0;
        ser_in    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            ser_valid = (t >= 9);
            ser_in    = 1'b0;
            @(posedge clk);
            #1;
        end
        check("midframe exp_data frozen", 32'(exp_data), 32'(4'b1000));
        check("midframe no done yet", 32'(done), 32'(0));
        #2 rst = 1'b1;
        ser_valid = 1'b0;
        #1;
        check("midframe async reset outputs", 32'({rx_data, exp_data, done, match, frame_err, overrun}), 32'(0));
        load_stim(vecs[0].start, vecs[0].nbits, vecs[0].bits, vecs[0].extra);
        run_case("post_reset", vecs[0].seed, vecs[0].want);

        for (int i = 0; i < 40; i++) begin
            r_seed  = 4'($urandom);
            r_start = $urandom_range(1, 12);
            r_n     = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : W;
            r_bits  = ($urandom_range(0, 1) == 1) ? warm_word(r_seed) : 4'($urandom);
            r_extra = 0;
            if ($urandom_range(0, 1) == 1) begin
                r_lo    = (r_n == W) ? r_start + W : r_start + r_n + 1;
                r_extra = $urandom_range(r_lo, MAXE);
            end
            load_stim(r_start, r_n, r_bits, r_extra);
            run_case($sformatf("rand%0d", i), r_seed, model(r_seed));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
